// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed common-anode seven-segment driver. A slow scan clock
//   from the divider is synchronised and edge-detected into a one-cycle
//   tick that steps the digit index. A loaded value waits in a shadow
//   register and is committed only when the scan wraps to digit 0, so a
//   frame never shows a mix of old and new digits.
//
// Ports
//   clk_in      system clock, all logic on posedge
//   reset       asynchronous, active-high
//   scan_in     slow scan clock, asynchronous phase
//   value_in    4*DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in       decimal points, bit i -> digit i, 1 = lit
//   load        1-cycle strobe capturing value_in/dp_in
//   blank_lz    1 = blank leading zero digits (sampled live)
//   an          anode enables, active-low
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_done  1-cycle pulse when the scan wraps to digit 0
//
// Scan/commit behaviour
//   state           | meaning
//   idx_q           | digit currently driven; reset to DIGITS-1 so the
//                   | first tick after reset is a wrap onto digit 0
//   pending_q = 0   | display_q is current, nothing queued
//   pending_q = 1   | shadow_q holds a newer value, committed at next wrap

module seg7_scan_driver #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_in,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);

  logic                s1_q, s2_q, s3_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q;

  logic                tick, idx_last, wrap;
  logic [3:0]          nib;
  logic                dp_bit, upper_zero, blanked;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = s2_q & ~s3_q;
    idx_last = (idx_q == IDX_W'(DIGITS - 1));
    wrap     = tick & idx_last;

    idx_d = idx_q;
    if (tick) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);

    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pending_d  = pending_q;
    if (load && wrap) begin
      // bypass: the shadow would be one cycle too late for this wrap
      disp_val_d = value_in;
      disp_dp_d  = dp_in;
      pending_d  = 1'b0;
    end else if (wrap && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end else if (load) begin
      pending_d  = 1'b1;
    end

    nib        = 4'h0;
    dp_bit     = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib    = disp_val_d[i*4 +: 4];
        dp_bit = disp_dp_d[i];
      end
      if (IDX_W'(i) >= idx_d && disp_val_d[i*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blanked = blank_lz & upper_zero & (idx_d != '0);

    an_d  = blanked ? '1 : ~(DIGITS'(1) << idx_d);
    seg_d = blanked ? 7'h7F : seg_decode(nib);
    dp_d  = blanked ? 1'b1 : ~dp_bit;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      idx_q        <= IDX_W'(DIGITS - 1);
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      s1_q       <= scan_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      idx_q      <= idx_d;
      if (load) begin
        shadow_val_q <= value_in;
        shadow_dp_q  <= dp_in;
      end
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pending_q  <= pending_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= wrap;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan_in;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan_driver #(.DIGITS(DIGITS)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .scan_in    (scan_in),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   tests    = 0;
  int   failures = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          m_idx;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  bit          m_pend;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t {an,seg,dp,fd} got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_idx = DIGITS - 1; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 0;
  endfunction

  function automatic void model_load(input logic [15:0] v, input logic [3:0] d);
    m_shadow = v; m_sdp = d; m_pend = 1;
  endfunction

  // Advance one digit slot and push the outputs expected at the update edge
  // and at the edge after it (frame_done must have dropped by then).
  function automatic void model_tick(input int due, input bit ld,
                                     input logic [15:0] v, input logic [3:0] d);
    logic [15:0] sh;
    logic [3:0]  nib;
    bit          lit;
    exp_t        e;
    m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
    if (m_idx == 0) begin
      if (ld) begin m_disp = v; m_ddp = d; m_pend = 0; end
      else if (m_pend) begin m_disp = m_shadow; m_ddp = m_sdp; m_pend = 0; end
    end else if (ld) begin
      model_load(v, d);
    end
    sh  = m_disp >> (4 * m_idx);
    nib = sh[3:0];
    lit = !(blank_lz && m_idx != 0 && sh == 16'h0);
    e.due = due;
    e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e.seg = lit ? seg_tbl[nib] : 7'h7F;
    e.dp  = lit ? ~m_ddp[m_idx] : 1'b1;
    e.fd  = (m_idx == 0);
    sb.push_back(e);
    e.due = due + 1;
    e.fd  = 1'b0;
    sb.push_back(e);
  endfunction

  // monitor: pops expectations whose update edge has just passed
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          tests++; failures++;
          $display("FAIL sb_late due=%0d now=%0d", e.due, cyc);
        end else begin
          check("scan", {an, seg, dp, frame_done}, {e.an, e.seg, e.dp, e.fd});
        end
      end
    end
  end

  // lmode: 0 = no load, 1 = load on the tick's update edge, 2 = load before the tick
  task automatic scan_pulse(input int lmode, input logic [15:0] v, input logic [3:0] d);
    int c;
    @(negedge clk_in);
    c = cyc;
    scan_in = 1'b1;
    if (lmode == 2) begin
      load = 1'b1; value_in = v; dp_in = d;
      model_load(v, d);
    end
    @(negedge clk_in);
    load = 1'b0;
    @(negedge clk_in);
    if (lmode == 1) begin
      load = 1'b1; value_in = v; dp_in = d;
    end
    model_tick(c + 3, lmode == 1, v, d);
    @(negedge clk_in);
    load = 1'b0;
    scan_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) scan_pulse(0, 16'h0, 4'h0);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check(name, {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  initial begin
    int mode;
    int wait_cyc;
    reset = 1'b1; scan_in = 1'b0; value_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    reset = 1'b0;

    // 1: first tick wraps onto digit 0
    pulses(4);
    // 2: load mid-frame, visible only after the next wrap
    scan_pulse(0, 16'h0, 4'h0);
    scan_pulse(2, 16'h12AF, 4'h0);
    pulses(2);
    pulses(4);
    // 3: load coincident with wrap -> bypass
    scan_pulse(1, 16'h8888, 4'h0);
    pulses(3);
    // 4: leading-zero blanking hides a set dp on a blanked digit
    blank_lz = 1'b1;
    scan_pulse(1, 16'h0050, 4'b1000);
    pulses(3);
    // 5: all zero -> only digit 0 lit
    scan_pulse(1, 16'h0000, 4'h0);
    pulses(3);
    // 6: reset mid-frame
    pulses(2);
    pulse_reset("reset_mid");
    pulses(4);
    // multiple loads within one frame: last one wins
    blank_lz = 1'b0;
    scan_pulse(2, 16'h1111, 4'h1);
    scan_pulse(1, 16'h2222, 4'h2);
    scan_pulse(2, 16'h3333, 4'h4);
    pulses(1);
    pulses(4);

    // randomized traffic
    for (int i = 0; i < 48; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      scan_pulse(mode, 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 29) == 0) pulse_reset("reset_rand");
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clk_in);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      tests++; failures++;
      $display("FAIL sb_drain left=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
